hex_countdown_display: RTL and testbench

//  N-digit hex value register driving N active-low 7-segment displays (HEX0..HEXn-1).

---
 rtl/hex_countdown_display.sv | 155 +++++++++++++++
 tb/tb_hex_countdown_display.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/hex_countdown_display.sv
// hex_countdown_display
//   N-digit hex value register with saturating decrement, zero flag and a
//   bank of registered active-low 7-segment outputs that can blink.
//   Optional feature macro: LEADING_ZERO_BLANK_EN
//     defined   -> zero digits above the most significant nonzero digit are
//                  blanked (digit 0 always shown)
//     undefined -> every digit always shows its hex glyph
module hex_countdown_display #(
  parameter int NUM_DIGITS = 2,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic                    dec,
  input  logic                    blink_en,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    zero,
  output logic [7*NUM_DIGITS-1:0] seg_n
);

  localparam int VW = 4 * NUM_DIGITS;
  localparam int SW = 7 * NUM_DIGITS;
  localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(BLINK_DIV - 1);
  localparam logic [6:0]    SEG_BLANK = 7'h7F;
  localparam logic [SW-1:0] SEG_ALL_BLANK = {SW{1'b1}};

`ifdef LEADING_ZERO_BLANK_EN
  // Value 0 with blanking: digit 0 shows "0" (7'h40), the rest are dark.
  localparam logic [SW-1:0] SEG_RESET = ~SW'(7'h3F);
`else
  localparam logic [SW-1:0] SEG_RESET = {NUM_DIGITS{7'h40}};
`endif

  // Standard hex glyphs, active-low, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  logic [VW-1:0] value_reg, value_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          phase_reg, phase_next;
  logic [SW-1:0] seg_reg, seg_next;
  logic [SW-1:0] glyphs;

  // Value register next state: load beats dec; dec saturates at zero.
  always_comb begin
    value_next = value_reg;
    if (load) begin
      value_next = load_value;
    end else if (dec && (value_reg != '0)) begin
      value_next = value_reg - VW'(1);
    end
  end

  // Value register.
  always_ff @(posedge clock) begin
    if (reset) begin
      value_reg <= '0;
    end else begin
      value_reg <= value_next;
    end
  end

  // Blink divider: counts only while enabled, toggles phase on wrap.
  always_comb begin
    cnt_next   = '0;
    phase_next = 1'b0;
    if (blink_en) begin
      phase_next = phase_reg;
      if (cnt_reg == CNT_LAST) begin
        cnt_next   = '0;
        phase_next = ~phase_reg;
      end else begin
        cnt_next = cnt_reg + CW'(1);
      end
    end
  end

  // Blink counter and phase registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_reg   <= '0;
      phase_reg <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      phase_reg <= phase_next;
    end
  end

  // Per-digit glyph selection, with optional leading-zero blanking.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [3:0] digit;
      assign digit = value_reg[4*gi +: 4];
`ifdef LEADING_ZERO_BLANK_EN
      if (gi == 0) begin : g_lsd
        assign glyphs[6:0] = hex_glyph(digit);
      end else if (gi == NUM_DIGITS - 1) begin : g_msd
        assign glyphs[7*gi +: 7] = (digit == 4'h0) ? SEG_BLANK : hex_glyph(digit);
      end else begin : g_mid
        logic nz_above;
        assign nz_above = |value_reg[VW-1:4*(gi+1)];
        assign glyphs[7*gi +: 7] = (!nz_above && (digit == 4'h0)) ? SEG_BLANK
                                                                  : hex_glyph(digit);
      end
`else
      assign glyphs[7*gi +: 7] = hex_glyph(digit);
`endif
    end
  endgenerate

  // Segment register input: blank phase overrides every digit.
  always_comb begin
    seg_next = glyphs;
    if (phase_reg) begin
      seg_next = SEG_ALL_BLANK;
    end
  end

  // Segment output register.
  always_ff @(posedge clock) begin
    if (reset) begin
      seg_reg <= SEG_RESET;
    end else begin
      seg_reg <= seg_next;
    end
  end

  assign value = value_reg;
  assign zero  = (value_reg == '0);
  assign seg_n = seg_reg;

endmodule

// File: tb/tb_hex_countdown_display.sv
// Directed testbench for hex_countdown_display (NUM_DIGITS=2, BLINK_DIV=4).
// Honors LEADING_ZERO_BLANK_EN when defined for the build.
module tb_hex_countdown_display;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic [7:0]  load_value = 8'h00;
  logic        dec = 1'b0;
  logic        blink_en = 1'b0;
  logic [7:0]  value;
  logic        zero;
  logic [13:0] seg_n;

  int pass_count = 0;
  int check_count = 0;

  localparam logic [13:0] BLANK = 14'h3FFF;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [13:0] SEG_00 = {7'h7F, 7'h40};
  localparam logic [13:0] SEG_0F = {7'h7F, 7'h0E};
`else
  localparam logic [13:0] SEG_00 = {7'h40, 7'h40};
  localparam logic [13:0] SEG_0F = {7'h40, 7'h0E};
`endif
  localparam logic [13:0] SEG_3A = {7'h30, 7'h08};
  localparam logic [13:0] SEG_77 = {7'h78, 7'h78};

  hex_countdown_display #(
    .NUM_DIGITS(2),
    .BLINK_DIV (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .load_value(load_value),
    .dec       (dec),
    .blink_en  (blink_en),
    .value     (value),
    .zero      (zero),
    .seg_n     (seg_n)
  );

  always #5 clock = ~clock;

  // Advance one rising edge, then settle 1 time unit before sampling/driving.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    load = 1'b1;
    load_value = 8'hCC;
    dec = 1'b1;
    step();
    reset = 1'b0;
    load = 1'b0;
    dec = 1'b0;
    check_count++;
    if (value !== 8'h00) $display("FAIL reset_value got=%h exp=00", value);
    else pass_count++;
    check_count++;
    if (zero !== 1'b1) $display("FAIL reset_zero got=%b exp=1", zero);
    else pass_count++;
    step();
    check_count++;
    if (seg_n !== SEG_00) $display("FAIL reset_seg got=%h exp=%h", seg_n, SEG_00);
    else pass_count++;
    $display("reset: value=%h zero=%b seg_n=%h", value, zero, seg_n);
  endtask

  task automatic test_load();
    load = 1'b1;
    load_value = 8'h3A;
    step();
    load = 1'b0;
    check_count++;
    if (value !== 8'h3A) $display("FAIL load_value got=%h exp=3A", value);
    else pass_count++;
    check_count++;
    if (zero !== 1'b0) $display("FAIL load_zero got=%b exp=0", zero);
    else pass_count++;
    check_count++;
    if (seg_n !== SEG_00) $display("FAIL load_seg_latency got=%h exp=%h", seg_n, SEG_00);
    else pass_count++;
    step();
    step();
    check_count++;
    if (seg_n !== SEG_3A) $display("FAIL load_seg got=%h exp=%h", seg_n, SEG_3A);
    else pass_count++;
    $display("load 3A: value=%h zero=%b seg_n=%h", value, zero, seg_n);
  endtask

  task automatic test_dec_borrow();
    load = 1'b1;
    load_value = 8'h10;
    step();
    load = 1'b0;
    dec = 1'b1;
    step();
    dec = 1'b0;
    check_count++;
    if (value !== 8'h0F) $display("FAIL borrow_value got=%h exp=0F", value);
    else pass_count++;
    step();
    check_count++;
    if (seg_n !== SEG_0F) $display("FAIL borrow_seg got=%h exp=%h", seg_n, SEG_0F);
    else pass_count++;
    $display("dec 10: value=%h seg_n=%h", value, seg_n);
  endtask

  task automatic test_dec_saturate();
    logic [7:0] exp_v [4];
    logic       exp_z [4];
    exp_v = '{8'h01, 8'h00, 8'h00, 8'h00};
    exp_z = '{1'b0, 1'b1, 1'b1, 1'b1};
    load = 1'b1;
    load_value = 8'h02;
    step();
    load = 1'b0;
    dec = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_count++;
      if (value !== exp_v[i]) $display("FAIL sat_value[%0d] got=%h exp=%h", i, value, exp_v[i]);
      else pass_count++;
      check_count++;
      if (zero !== exp_z[i]) $display("FAIL sat_zero[%0d] got=%b exp=%b", i, zero, exp_z[i]);
      else pass_count++;
      $display("dec step %0d: value=%h zero=%b", i, value, zero);
    end
    dec = 1'b0;
    step();
    check_count++;
    if (seg_n !== SEG_00) $display("FAIL sat_seg got=%h exp=%h", seg_n, SEG_00);
    else pass_count++;
  endtask

  task automatic test_load_wins();
    load = 1'b1;
    dec = 1'b1;
    load_value = 8'h55;
    step();
    load = 1'b0;
    dec = 1'b0;
    check_count++;
    if (value !== 8'h55) $display("FAIL load_wins got=%h exp=55", value);
    else pass_count++;
    $display("load+dec 55: value=%h", value);
  endtask

  task automatic test_blink();
    logic [13:0] exp_seg;
    load = 1'b1;
    load_value = 8'h77;
    step();
    load = 1'b0;
    step();
    blink_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      exp_seg = ((i / 4) % 2 == 1) ? BLANK : SEG_77;
      check_count++;
      if (seg_n !== exp_seg) $display("FAIL blink_seg[%0d] got=%h exp=%h", i, seg_n, exp_seg);
      else pass_count++;
      check_count++;
      if (value !== 8'h77) $display("FAIL blink_value[%0d] got=%h exp=77", i, value);
      else pass_count++;
      $display("blink cycle %0d: seg_n=%h value=%h", i, seg_n, value);
    end
    // Phase toggled to blank on the last edge; dropping enable clears it.
    blink_en = 1'b0;
    step();
    check_count++;
    if (seg_n !== BLANK) $display("FAIL unblink_seg1 got=%h exp=%h", seg_n, BLANK);
    else pass_count++;
    step();
    check_count++;
    if (seg_n !== SEG_77) $display("FAIL unblink_seg2 got=%h exp=%h", seg_n, SEG_77);
    else pass_count++;
    check_count++;
    if (value !== 8'h77) $display("FAIL unblink_value got=%h exp=77", value);
    else pass_count++;
    $display("blink off: seg_n=%h value=%h", seg_n, value);
  endtask

  task automatic test_reset_mid();
    load = 1'b1;
    load_value = 8'h3A;
    step();
    load = 1'b0;
    dec = 1'b1;
    blink_en = 1'b1;
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    dec = 1'b0;
    check_count++;
    if (value !== 8'h00) $display("FAIL midreset_value got=%h exp=00", value);
    else pass_count++;
    check_count++;
    if (zero !== 1'b1) $display("FAIL midreset_zero got=%b exp=1", zero);
    else pass_count++;
    // Blink counter restarted from 0: 4 visible edges, then blank.
    for (int i = 0; i < 5; i++) begin
      step();
      check_count++;
      if (seg_n !== ((i < 4) ? SEG_00 : BLANK))
        $display("FAIL midreset_seg[%0d] got=%h exp=%h", i, seg_n, (i < 4) ? SEG_00 : BLANK);
      else pass_count++;
      $display("after mid reset %0d: seg_n=%h", i, seg_n);
    end
    blink_en = 1'b0;
    step();
  endtask

  initial begin
    #2;
    test_reset();
    test_load();
    test_dec_borrow();
    test_dec_saturate();
    test_load_wins();
    test_blink();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
